// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg: shared FSM state type and default widths for the sqrt engine arbiter
package sqrt_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int OP_W_DEF  = 16;
   localparam int RES_W_DEF = 8;
endpackage

// File: rtl/sqrt_arb_rr_pick.sv
// sqrt_arb_rr_pick: combinational round-robin picker
//  req  in  N        request levels
//  ptr  in  IW       highest-priority requester this round
//  win  out N        one-hot winner (0 when no request)
//  idx  out IW       winner index (0 when no request)
module sqrt_arb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] j;
   // Scan from farthest to nearest so the requester closest to ptr overwrites last.
   always_comb begin
      win = '0;
      idx = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) idx = j;
      end
      win[idx] = |req;
   end
endmodule

// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin sharing of one iterative square-root engine among NUM_REQ requesters
//  clk, rst (async, active-high)
//  req/op_in        requester levels and packed operands (requester i at [i*OP_W +: OP_W])
//  gnt              one-cycle pulse when requester's operand is captured
//  rsp_vld/rsp_sqrt/rsp_err  one-cycle result return to the served requester
//  busy             arbiter not idle
//  eng_go/eng_op    engine start pulse and operand
//  eng_sqrt/eng_done/eng_err engine result, sticky done, negative-operand flag
//  Optional macro SQRT_ARB_NEG_BYPASS_EN: negative operands answered without using the engine.
module sqrt_arb
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int OP_W    = OP_W_DEF,
   parameter int RES_W   = RES_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*OP_W-1:0] op_in,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      rsp_vld,
   output logic [RES_W-1:0]        rsp_sqrt,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    eng_go,
   output logic [OP_W-1:0]         eng_op,
   input  logic [RES_W-1:0]        eng_sqrt,
   input  logic                    eng_done,
   input  logic                    eng_err
);
   localparam int IW = $clog2(NUM_REQ);
   state_t             state, nxt;
   logic [IW-1:0]      ptr, idx, pick_idx;
   logic [NUM_REQ-1:0] pick_win;
   logic [OP_W-1:0]    op_q;
   logic [RES_W-1:0]   res_q;
   logic               err_q, byp_neg;

   sqrt_arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req (req),
      .ptr (ptr),
      .win (pick_win),
      .idx (pick_idx)
   );

`ifdef SQRT_ARB_NEG_BYPASS_EN
   assign byp_neg = op_q[OP_W-1];
`else
   assign byp_neg = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = |pick_win ? ISSUE : IDLE;
         ISSUE:   nxt = byp_neg ? RESP : WAIT;
         WAIT:    nxt = eng_done ? RESP : WAIT;
         default: nxt = IDLE;
      endcase
   end

   // Strobes decode only registered state/idx so no combinational path from req reaches them.
   assign gnt      = (state == ISSUE) ? NUM_REQ'(1) << idx : '0;
   assign rsp_vld  = (state == RESP) ? NUM_REQ'(1) << idx : '0;
   assign eng_go   = (state == ISSUE) && !byp_neg;
   assign eng_op   = op_q;
   assign busy     = (state != IDLE);
   assign rsp_sqrt = (state == RESP) ? res_q : '0;
   assign rsp_err  = (state == RESP) && err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         op_q  <= '0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && |pick_win) begin
            idx  <= pick_idx;
            op_q <= op_in[int'(pick_idx)*OP_W +: OP_W];
         end
         if (state == ISSUE && byp_neg) begin
            res_q <= '0;
            err_q <= 1'b1;
         end
         if (state == WAIT && eng_done) begin
            res_q <= eng_err ? '0 : eng_sqrt;
            err_q <= eng_err;
         end
         if (state == RESP) ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_sqrt_arb.sv
// tb_sqrt_arb: randomized scoreboard bench for sqrt_arb with a behavioural engine stand-in
module tb_sqrt_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] op_in;
   logic [3:0]  gnt, rsp_vld;
   logic [7:0]  rsp_sqrt, eng_sqrt;
   logic        rsp_err, busy, eng_go, eng_done, eng_err;
   logic [15:0] eng_op;

`ifdef SQRT_ARB_NEG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   sqrt_arb dut (
      .clk(clk), .rst(rst), .req(req), .op_in(op_in), .gnt(gnt), .rsp_vld(rsp_vld),
      .rsp_sqrt(rsp_sqrt), .rsp_err(rsp_err), .busy(busy), .eng_go(eng_go), .eng_op(eng_op),
      .eng_sqrt(eng_sqrt), .eng_done(eng_done), .eng_err(eng_err)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Engine stand-in: done 9 cycles after go for non-negative, 2 cycles for negative;
   // returns garbage sqrt on error so the arbiter's zero-forcing is visible.
   logic [3:0]  e_cnt;
   logic        e_run;
   logic [15:0] e_op;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_done <= 1'b0;
         eng_err  <= 1'b0;
         eng_sqrt <= '0;
         e_run    <= 1'b0;
         e_cnt    <= '0;
         e_op     <= '0;
      end else if (eng_go) begin
         eng_done <= 1'b0;
         eng_err  <= 1'b0;
         e_run    <= 1'b1;
         e_cnt    <= eng_op[15] ? 4'd0 : 4'd7;
         e_op     <= eng_op;
      end else if (e_run) begin
         if (e_cnt == 0) begin
            e_run    <= 1'b0;
            eng_done <= 1'b1;
            eng_err  <= e_op[15];
            eng_sqrt <= e_op[15] ? 8'hA5 : 8'(isqrt(int'(e_op)));
         end else e_cnt <= e_cnt - 1'b1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          idx;
      logic [15:0] op;
      int          sq;
      int          er;
      int          lat;
   } exp_t;
   exp_t sb[$];

   function automatic void push(int w, logic [15:0] o);
      exp_t e;
      e.idx = w;
      e.op  = o;
      e.er  = int'(o[15]);
      e.sq  = o[15] ? 0 : isqrt(int'(o));
      e.lat = o[15] ? (BYP ? 1 : 3) : 10;
      sb.push_back(e);
   endfunction

   // Monitor: checks grants and responses against the head of the scoreboard.
   int gcyc = 0;
   always @(negedge clk) begin
      if (rst) sb.delete();
      else begin
         if (gnt != 0) begin
            if (sb.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
            else begin
               chk("gnt", int'(gnt), 1 << sb[0].idx);
               chk("eng_go", int'(eng_go), (BYP && sb[0].op[15]) ? 0 : 1);
               if (eng_go) chk("eng_op", int'(eng_op), int'(sb[0].op));
               gcyc = cyc;
            end
         end else if (eng_go) chk("eng_go_stray", int'(eng_go), 0);
         if (rsp_vld != 0) begin
            if (sb.size() == 0) chk("rsp_unexpected", int'(rsp_vld), 0);
            else begin
               chk("rsp_vld", int'(rsp_vld), 1 << sb[0].idx);
               chk("rsp_sqrt", int'(rsp_sqrt), sb[0].sq);
               chk("rsp_err", int'(rsp_err), sb[0].er);
               chk("rsp_latency", cyc - gcyc, sb[0].lat);
               chk("busy_resp", int'(busy), 1);
               void'(sb.pop_front());
            end
         end
      end
   end

   int          need[4];
   logic [15:0] opa[4], opb[4];
   int          ptr_m = 0;

   task automatic clear();
      for (int i = 0; i < 4; i++) begin
         need[i] = 0;
         opa[i] = '0;
         opb[i] = '0;
      end
   endtask

   // Requester i asks need[i] times (opa then opb); the model predicts the round-robin
   // service order up front, and each requester keeps req high until served enough.
   task automatic run();
      int pend[4], got[4];
      int tot = 0, done_g = 0, budget = 0, last_rsp = -1, c0;
      for (int i = 0; i < 4; i++) begin
         pend[i] = need[i];
         got[i] = 0;
         tot += need[i];
      end
      for (int s = 0; s < tot; s++) begin
         int w = -1;
         for (int k = 0; k < 4; k++) if (w < 0 && pend[(ptr_m + k) % 4] > 0) w = (ptr_m + k) % 4;
         pend[w]--;
         push(w, (need[w] - pend[w] == 1) ? opa[w] : opb[w]);
         ptr_m = (w + 1) % 4;
      end
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         req[i] = need[i] > 0;
         op_in[i*16 +: 16] = opa[i];
      end
      while ((done_g < tot || sb.size() > 0) && budget < 20 * tot + 40) begin
         @(negedge clk);
         budget++;
         if (gnt != 0) begin
            if (done_g == 0) chk("first_gnt_latency", cyc - c0, 1);
            if (last_rsp >= 0) chk("b2b_gap", cyc - last_rsp, 2);
            for (int i = 0; i < 4; i++) if (gnt[i]) begin
               got[i]++;
               if (got[i] >= need[i]) req[i] = 1'b0;
               else op_in[i*16 +: 16] = opb[i];
            end
            done_g++;
         end
         if (rsp_vld != 0) last_rsp = cyc;
      end
      if (done_g < tot || sb.size() > 0) chk("timeout_pending", tot - done_g + sb.size(), 0);
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      op_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_eng_go", int'(eng_go), 0);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("idle_busy", int'(busy), 0);
         chk("idle_gnt", int'(gnt), 0);
         chk("idle_rsp_vld", int'(rsp_vld), 0);
         chk("idle_eng_go", int'(eng_go), 0);
         chk("idle_rsp_sqrt", int'(rsp_sqrt), 0);
         chk("idle_rsp_err", int'(rsp_err), 0);
      end
      // All four held: service 0,1,2,3,0.
      clear();
      need = '{2, 1, 1, 1};
      opa = '{16'd16, 16'd100, 16'd255, 16'h7FFF};
      opb[0] = 16'd16;
      run();
      clear();
      need[0] = 1;
      opa[0] = 16'd625;
      run();
      clear();
      need[2] = 1;
      opa[2] = 16'h8000;
      run();
      // Reset pulsed while the engine is working.
      push(1, 16'd400);
      req[1] = 1'b1;
      op_in[16 +: 16] = 16'd400;
      for (int t = 0; t < 20 && gnt == 0; t++) @(negedge clk);
      chk("rst_gnt", int'(gnt), 2);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = '0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ptr_m = 0;
      repeat (15) begin
         @(negedge clk);
         chk("post_rst_rsp_vld", int'(rsp_vld), 0);
         chk("post_rst_busy", int'(busy), 0);
      end
      clear();
      need[1] = 1;
      opa[1] = 16'd400;
      run();
      clear();
      need[3] = 2;
      opa[3] = 16'd49;
      opb[3] = 16'd50;
      run();
      for (int r = 0; r < 20; r++) begin
         clear();
         for (int i = 0; i < 4; i++) begin
            need[i] = $urandom_range(0, 2);
            opa[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) | 16'h8000 : 16'($urandom) & 16'h7FFF;
            opb[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) | 16'h8000 : 16'($urandom) & 16'h7FFF;
         end
         if (need[0] + need[1] + need[2] + need[3] == 0) need[r % 4] = 1;
         run();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
